// File: rtl/ram_word_sequencer_if.sv
// ram_word_sequencer_if
// Bundles the receiver request, transmitter handshake, RAM port and status
// signals of the word sequencer. The slave modport is the sequencer's view;
// the master modport is the view of whatever surrounds it (receiver,
// transmitter, RAM, status consumers).
interface ram_word_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    // Receiver side
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    // Control levels
    logic              send;
    logic              clear;
    // RAM port
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // Transmitter side
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    // Status
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              busy;
    logic              done;

    modport slave (
        input  wr_req, wr_data, send, clear, ram_rdata, tx_ready,
        output wr_ack, ram_addr, ram_we, ram_wdata, tx_data, tx_valid,
               word_count, full, busy, done
    );

    modport master (
        output wr_req, wr_data, send, clear, ram_rdata, tx_ready,
        input  wr_ack, ram_addr, ram_we, ram_wdata, tx_data, tx_valid,
               word_count, full, busy, done
    );
endinterface

// File: rtl/ram_word_sequencer.sv
// ram_word_sequencer
// Sole owner of the single-port word RAM. In IDLE it appends words from the
// receiver at consecutive addresses; on send it reads every stored word back
// in address order and offers each to the transmitter over valid/ready.
// All outputs are registered; the RAM read has one cycle of latency.
// Optional feature: define RAM_SEQ_CLEAR_ON_SEND_EN to zero the word count
// at the end of every playback (each batch plays back once).
module ram_word_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ram_word_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_WAIT,
        TX_HOLD,
        DONE
    } state_t;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_inc;
    logic              last_word;

    // Count after the word in flight lands; its MSB is the next full flag.
    assign count_inc = bus.word_count + (ADDR_W+1)'(1);
    // rd_ptr reaches the last stored word (count is never 0 during playback).
    assign last_word = ({1'b0, rd_ptr} == bus.word_count - (ADDR_W+1)'(1));

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            bus.wr_ack     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_we     <= 1'b0;
            bus.ram_wdata  <= ZERO_WORD;
            bus.tx_data    <= ZERO_WORD;
            bus.tx_valid   <= 1'b0;
            bus.word_count <= '0;
            bus.full       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            // NOTE: single-cycle pulses default low here and are raised only
            // on the transition into their state; every register update uses
            // non-blocking assignment so all branches see pre-edge values.
            bus.wr_ack <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        bus.word_count <= '0;
                        bus.full       <= 1'b0;
                        bus.ram_addr   <= '0;
                    end else if (bus.send && (bus.word_count != '0)) begin
                        rd_ptr       <= '0;
                        bus.ram_addr <= '0;
                        bus.busy     <= 1'b1;
                        state        <= RD_ADDR;
                    end else if (bus.wr_req && !bus.full) begin
                        bus.ram_addr  <= bus.word_count[ADDR_W-1:0];
                        bus.ram_wdata <= bus.wr_data;
                        bus.ram_we    <= 1'b1;
                        bus.wr_ack    <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= WRITE;
                    end
                end

                WRITE: begin
                    // The idle RAM address tracks the next free slot.
                    bus.word_count <= count_inc;
                    bus.full       <= count_inc[ADDR_W];
                    bus.ram_addr   <= count_inc[ADDR_W-1:0];
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end

                RD_ADDR: begin
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    bus.tx_data  <= bus.ram_rdata;
                    bus.tx_valid <= 1'b1;
                    state        <= TX_HOLD;
                end

                TX_HOLD: begin
                    // Address stays on the current word until the handshake,
                    // so no later word is read early.
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        if (last_word) begin
                            bus.ram_addr <= bus.word_count[ADDR_W-1:0];
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end else begin
                            rd_ptr       <= rd_ptr + 1'b1;
                            bus.ram_addr <= rd_ptr + 1'b1;
                            state        <= RD_ADDR;
                        end
                    end
                end

                DONE: begin
`ifdef RAM_SEQ_CLEAR_ON_SEND_EN
                    bus.word_count <= '0;
                    bus.full       <= 1'b0;
                    bus.ram_addr   <= '0;
`endif
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.tx_valid <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_word_sequencer.sv
// tb_ram_word_sequencer
// Directed bench for ram_word_sequencer: a cycle table for record-and-play,
// then hand-written sequences for backpressure, empty send, simultaneous
// inputs, full RAM and reset during playback. The bench owns the RAM model.
module tb_ram_word_sequencer;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

`ifdef RAM_SEQ_CLEAR_ON_SEND_EN
    localparam logic [8:0] CNT_AFTER = 9'd0;   // count after 3-word playback
    localparam logic [7:0] SIM_ADDR  = 8'd0;   // address of write held across playback
    localparam logic [8:0] SIM_CNT   = 9'd1;
`else
    localparam logic [8:0] CNT_AFTER = 9'd3;
    localparam logic [7:0] SIM_ADDR  = 8'd1;
    localparam logic [8:0] SIM_CNT   = 9'd2;
`endif

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_seen  = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    ram_word_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_word_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            we_seen           <= we_seen + 1;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr_req;
        logic [15:0] wr_data;
        logic        send;
        logic        clear;
        logic        tx_ready;
        logic        e_ack;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        logic        e_busy;
        logic [8:0]  e_count;
        logic        e_valid;
        logic [15:0] e_txd;
        logic        e_done;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(
        input logic wr, input logic [15:0] d, input logic s, input logic c, input logic r,
        input logic ack, input logic we, input logic [7:0] addr, input logic [15:0] wd,
        input logic bsy, input logic [8:0] cnt, input logic v, input logic [15:0] txd,
        input logic dn);
        vec_t t;
        t.wr_req = wr;  t.wr_data = d;   t.send = s;     t.clear = c;  t.tx_ready = r;
        t.e_ack  = ack; t.e_we    = we;  t.e_addr = addr; t.e_wdata = wd;
        t.e_busy = bsy; t.e_count = cnt; t.e_valid = v;  t.e_txd = txd; t.e_done = dn;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.tx_valid;
            1:       return bus.done;
            default: return bus.wr_ack;
        endcase
    endfunction

    // Waits at negedges for a DUT pulse/level, bounded by budget cycles.
    task automatic wait_for(input int which, input string name, input int budget);
        int n = 0;
        while (!sig(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, sig(which)}, 32'd1);
    endtask

    task automatic do_reset();
        bus.wr_req = 1'b0; bus.wr_data = '0; bus.send = 1'b0;
        bus.clear = 1'b0; bus.tx_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_word(input logic [15:0] d);
        bus.wr_req  = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        wait_for(2, "write wr_ack", 20);
        bus.wr_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] held;
        int          base;
        logic [7:0]  b;

        reset_n = 1'b0;
        bus.wr_req = 1'b0; bus.wr_data = '0; bus.send = 1'b0;
        bus.clear = 1'b0; bus.tx_ready = 1'b0;
        @(negedge clk);

        // ---- Reset state ----
        check("reset wr_ack",     bus.wr_ack,     0);
        check("reset ram_we",     bus.ram_we,     0);
        check("reset ram_addr",   bus.ram_addr,   0);
        check("reset tx_valid",   bus.tx_valid,   0);
        check("reset tx_data",    bus.tx_data,    0);
        check("reset word_count", bus.word_count, 0);
        check("reset full",       bus.full,       0);
        check("reset busy",       bus.busy,       0);
        check("reset done",       bus.done,       0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---- Record and play, one row per clock ----
        //             wr d       s  c  r    ack we addr  wdata    bsy cnt      v  txd      dn
        tbl[0]  = mk(1, 16'h1111, 0, 0, 0,   1, 1, 8'd0, 16'h1111, 1, 9'd0,     0, 16'h0000, 0);
        tbl[1]  = mk(0, 16'h0000, 0, 0, 0,   0, 0, 8'd1, 16'h0000, 0, 9'd1,     0, 16'h0000, 0);
        tbl[2]  = mk(1, 16'h2222, 0, 0, 0,   1, 1, 8'd1, 16'h2222, 1, 9'd1,     0, 16'h0000, 0);
        tbl[3]  = mk(0, 16'h0000, 0, 0, 0,   0, 0, 8'd2, 16'h0000, 0, 9'd2,     0, 16'h0000, 0);
        tbl[4]  = mk(1, 16'h3333, 0, 0, 0,   1, 1, 8'd2, 16'h3333, 1, 9'd2,     0, 16'h0000, 0);
        tbl[5]  = mk(0, 16'h0000, 0, 0, 0,   0, 0, 8'd3, 16'h0000, 0, 9'd3,     0, 16'h0000, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 0, 1,   0, 0, 8'd0, 16'h0000, 1, 9'd3,     0, 16'h0000, 0);
        tbl[7]  = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd0, 16'h0000, 1, 9'd3,     0, 16'h0000, 0);
        tbl[8]  = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd0, 16'h0000, 1, 9'd3,     1, 16'h1111, 0);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd1, 16'h0000, 1, 9'd3,     0, 16'h1111, 0);
        tbl[10] = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd1, 16'h0000, 1, 9'd3,     0, 16'h1111, 0);
        tbl[11] = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd1, 16'h0000, 1, 9'd3,     1, 16'h2222, 0);
        tbl[12] = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd2, 16'h0000, 1, 9'd3,     0, 16'h2222, 0);
        tbl[13] = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd2, 16'h0000, 1, 9'd3,     0, 16'h2222, 0);
        tbl[14] = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd2, 16'h0000, 1, 9'd3,     1, 16'h3333, 0);
        // busy has been high for 10 = 3K+1 cycles here, done in the last one
        tbl[15] = mk(0, 16'h0000, 0, 0, 1,   0, 0, 8'd3, 16'h0000, 1, 9'd3,     0, 16'h3333, 1);
        tbl[16] = mk(0, 16'h0000, 0, 0, 1,   0, 0, CNT_AFTER[7:0], 16'h0000, 0, CNT_AFTER, 0, 16'h3333, 0);

        for (int i = 0; i < 17; i++) begin
            bus.wr_req   = tbl[i].wr_req;
            bus.wr_data  = tbl[i].wr_data;
            bus.send     = tbl[i].send;
            bus.clear    = tbl[i].clear;
            bus.tx_ready = tbl[i].tx_ready;
            @(negedge clk);
            check($sformatf("row%0d wr_ack", i),     bus.wr_ack,     tbl[i].e_ack);
            check($sformatf("row%0d ram_we", i),     bus.ram_we,     tbl[i].e_we);
            check($sformatf("row%0d ram_addr", i),   bus.ram_addr,   tbl[i].e_addr);
            if (tbl[i].e_we)
                check($sformatf("row%0d ram_wdata", i), bus.ram_wdata, tbl[i].e_wdata);
            check($sformatf("row%0d busy", i),       bus.busy,       tbl[i].e_busy);
            check($sformatf("row%0d word_count", i), bus.word_count, tbl[i].e_count);
            check($sformatf("row%0d tx_valid", i),   bus.tx_valid,   tbl[i].e_valid);
            check($sformatf("row%0d tx_data", i),    bus.tx_data,    tbl[i].e_txd);
            check($sformatf("row%0d done", i),       bus.done,       tbl[i].e_done);
        end
        bus.tx_ready = 1'b0;

        // ---- Backpressure: 7 cycles of tx_ready low on the first word ----
        do_reset();
        write_word(16'hA0A0);
        write_word(16'hB0B0);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        wait_for(0, "bp first tx_valid", 10);
        held = bus.tx_data;
        check("bp first tx_data", held, 16'hA0A0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp tx_valid held", bus.tx_valid, 1);
            check("bp tx_data held",  bus.tx_data,  16'hA0A0);
            check("bp ram_addr held", bus.ram_addr, 0);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("bp valid drop",   bus.tx_valid, 0);
        check("bp next address", bus.ram_addr, 1);
        wait_for(0, "bp second tx_valid", 10);
        check("bp second tx_data", bus.tx_data, 16'hB0B0);
        wait_for(1, "bp done", 10);
        bus.tx_ready = 1'b0;
        @(negedge clk);

        // ---- Empty send ----
        do_reset();
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("empty busy", bus.busy, 0);
            check("empty done", bus.done, 0);
            @(negedge clk);
        end

        // ---- send and wr_req together: playback first, then the write ----
        do_reset();
        write_word(16'h5A5A);
        bus.tx_ready = 1'b1;
        bus.send     = 1'b1;
        bus.wr_req   = 1'b1;
        bus.wr_data  = 16'hC3C3;
        @(negedge clk);
        bus.send = 1'b0;
        check("sim busy",       bus.busy,   1);
        check("sim no ack yet", bus.wr_ack, 0);
        check("sim no we yet",  bus.ram_we, 0);
        wait_for(0, "sim tx_valid", 10);
        check("sim tx_data", bus.tx_data, 16'h5A5A);
        check("sim ack during playback", bus.wr_ack, 0);
        wait_for(1, "sim done", 10);
        wait_for(2, "sim pending ack", 5);
        check("sim write addr",  bus.ram_addr,  SIM_ADDR);
        check("sim write data",  bus.ram_wdata, 16'hC3C3);
        bus.wr_req   = 1'b0;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        check("sim word_count", bus.word_count, SIM_CNT);
        check("sim ram content", mem[SIM_ADDR], 16'hC3C3);
        // clear wins over send
        bus.clear = 1'b1;
        bus.send  = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.send  = 1'b0;
        check("clr+send count", bus.word_count, 0);
        for (int i = 0; i < 3; i++) begin
            check("clr+send busy", bus.busy, 0);
            @(negedge clk);
        end

        // ---- Full: 256 writes, 257th refused, clear ----
        do_reset();
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            write_word({~b, b});
        end
        check("full flag",       bus.full,       1);
        check("full word_count", bus.word_count, 256);
        check("full idle addr",  bus.ram_addr,   0);
        check("full mem[0]",     mem[0],   16'hFF00);
        check("full mem[128]",   mem[128], 16'h7F80);
        check("full mem[255]",   mem[255], 16'h00FF);
        base = we_seen;
        bus.wr_req  = 1'b1;
        bus.wr_data = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("full no wr_ack", bus.wr_ack, 0);
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        check("full no RAM write", we_seen - base, 0);
        check("full mem[0] kept",  mem[0], 16'hFF00);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear word_count", bus.word_count, 0);
        check("clear full",       bus.full,       0);
        check("clear ram_addr",   bus.ram_addr,   0);

        // ---- Reset in TX_HOLD of word 2 of 4 ----
        do_reset();
        write_word(16'h0101);
        write_word(16'h0202);
        write_word(16'h0303);
        write_word(16'h0404);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        wait_for(0, "rst word1 tx_valid", 10);
        check("rst word1 tx_data", bus.tx_data, 16'h0101);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        wait_for(0, "rst word2 tx_valid", 10);
        check("rst word2 tx_data", bus.tx_data, 16'h0202);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst tx_valid",   bus.tx_valid,   0);
        check("rst busy",       bus.busy,       0);
        check("rst word_count", bus.word_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.send     = 1'b1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("post-rst busy",     bus.busy,     0);
            check("post-rst tx_valid", bus.tx_valid, 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_word_sequencer.md
# ram_word_sequencer

- Single owner of the 256×16 single-port word RAM between the serial receiver and the serial transmitter.
- Record phase: appends assembled words at consecutive addresses.
- Playback phase: on `send`, reads every stored word back in address order and hands each one to the transmitter over a valid/ready handshake.
- Write and read access to the RAM are mutually exclusive, and every RAM address and control signal comes from this block.

## Interface
- `ADDR_W`, 8, RAM address width; depth = 2^ADDR_W
- `DATA_W`, 16, RAM word width
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_req`  in  1  receiver has a word on `wr_data`; held until `wr_ack`
- `wr_data`  in  DATA_W  word to store
- `wr_ack`  out  1  one-cycle pulse: word written to RAM
- `send`  in  1  level; starts playback when sampled high in IDLE
- `clear`  in  1  level; zeroes word count when sampled high in IDLE
- `ram_addr`  out  ADDR_W  RAM address
- `ram_we`  out  1  RAM write enable
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after the address (registered read)
- `tx_data`  out  DATA_W  word offered to transmitter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter accepts `tx_data`
- `word_count`  out  ADDR_W+1  number of stored words, 0..2^ADDR_W
- `full`  out  1  `word_count == 2^ADDR_W`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of playback

## Operation
- **States:** IDLE, WRITE, RD_ADDR, RD_WAIT, TX_HOLD, DONE. All outputs are registered.
- **Reset:** all outputs 0, internal `rd_ptr` 0, state IDLE. Reset is asynchronous and may occur in any state; it aborts any write or playback in progress and `word_count` returns to 0.
- **IDLE priority:** `clear` > `send` > `wr_req`.
  - `clear`: `word_count` ← 0; stay in IDLE.
  - `send` with `word_count > 0`: `rd_ptr` ← 0; go to RD_ADDR.
  - `send` with `word_count == 0`: ignored; stay in IDLE, no `done`.
  - `wr_req` with `!full`: go to WRITE.
  - `wr_req` with `full`: not acknowledged; the requester waits.
- **WRITE** (1 cycle):
  - Drives `ram_we`=1, `ram_addr`=`word_count[ADDR_W-1:0]`, `ram_wdata`=`wr_data`, `wr_ack`=1.
  - `word_count` increments at the end of the cycle; state returns to IDLE.
- **RD_ADDR:** `ram_addr`=`rd_ptr`, `ram_we`=0; go to RD_WAIT.
- **RD_WAIT:** capture `ram_rdata` into `tx_data`; `tx_valid` ← 1; go to TX_HOLD.
- **TX_HOLD:** hold `tx_data`/`tx_valid` stable until `tx_ready` is high. On the transfer edge:
  - `tx_valid` ← 0.
  - If `rd_ptr == word_count-1`: go to DONE.
  - Otherwise `rd_ptr` ← `rd_ptr+1` and go to RD_ADDR.
- **DONE** (1 cycle): `done`=1; go to IDLE.
- **Input masking:** `wr_req`, `send` and `clear` are ignored outside IDLE.
- **Write data after playback:** words written after a playback are appended after the existing words.
- **`rd_ptr` width:** ADDR_W bits. The maximum value, 2^ADDR_W−1, is reached only when `full`; `rd_ptr` never wraps.
- **Idle RAM port:** `ram_we`=0, `ram_addr`=`word_count[ADDR_W-1:0]`; at `full` this address is 0.

## Timing
- **Write:** `wr_req` sampled high at edge N → `wr_ack`/`ram_we` high during cycle N+1 → `word_count` updated at edge N+2.
  - `wr_req` still high at edge N+2 is a new request.
  - Maximum rate: one word per 2 cycles.
- **Playback start:** `send` sampled at edge N → `busy` high from N+1 → first `tx_valid` high from N+3.
- **Per word:** 3 cycles minimum with `tx_ready` held high (RD_ADDR, RD_WAIT, TX_HOLD).
  - Playback of K words with `tx_ready`=1 takes 3K+1 cycles from `busy` rise to `done` pulse.
- **Flag timing:** `full` and `busy` update in the same cycle as the `word_count` change or state change that causes them.

## Configuration
- **`RAM_SEQ_CLEAR_ON_SEND_EN` defined:** DONE also sets `word_count` ← 0. Each recorded batch plays back once and the next write lands at address 0.
- **Undefined:** `word_count` is retained after playback. Repeated `send` replays the same words, and new writes append.

## Test plan
- **Record and play:** write 0x1111, 0x2222, 0x3333 (3 `wr_ack` pulses, `word_count`=3), then `send` with `tx_ready`=1 → `tx_data` 0x1111, 0x2222, 0x3333 in order; `done` 10 cycles after `busy` rises; macro off: `word_count` stays 3, macro on: `word_count` becomes 0.
- **Backpressure:** 2 stored words; hold `tx_ready`=0 for 7 cycles after the first `tx_valid` → `tx_data` stable and `tx_valid` high throughout; no `rd_ptr` advance; no RAM read of address 1 before the handshake.
- **Full:** 256 writes → `full`=1, `word_count`=256; the 257th `wr_req` receives no `wr_ack` and RAM is unchanged; `clear` → `word_count`=0, `full`=0.
- **Simultaneous inputs:** `send` and `wr_req` high in the same IDLE cycle with 1 stored word → playback runs first, then the pending write is acked and stored at address 1; `clear`+`send` together → count 0, no playback.
- **Empty send:** `send` with `word_count`=0 → `busy` stays 0, no `done`.
- **Reset mid-playback:** assert `reset_n`=0 in TX_HOLD of word 2 of 4 → immediately `tx_valid`=0, `busy`=0, `word_count`=0; after release, a `send` produces no playback.
